// File: rtl/alu_pkg.sv
// Shared opcode and FSM encodings for the multicycle ALU.
package alu_pkg;

   localparam int unsigned DefaultWidth = 32;

   typedef enum logic [3:0] {
      OpAdd = 4'd0,
      OpSub = 4'd1,
      OpAnd = 4'd2,
      OpOr  = 4'd3,
      OpShr = 4'd4,
      OpShl = 4'd5,
      OpRor = 4'd6,
      OpRol = 4'd7,
      OpNeg = 4'd8,
      OpNot = 4'd9,
      OpMul = 4'd10,
      OpDiv = 4'd11
   } alu_op_e;

   typedef enum logic [1:0] {
      StIdle,
      StMul,
      StDiv,
      StDone
   } alu_state_e;

endpackage

// File: rtl/seq_divider.sv
// Signed restoring divider, one quotient bit per cycle after load.
// quotient/remainder are the final sign-corrected results, valid while last is high.
module seq_divider #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             last
);

   localparam int unsigned CW = $clog2(WIDTH);

   logic             run_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] q_q, r_q, d_q;
   logic             neg_q_q, neg_r_q;

   logic [WIDTH-1:0] dividend_abs, divisor_abs;
   logic [WIDTH:0]   r_sh;
   logic             fits;
   logic [WIDTH-1:0] r_nx, q_nx;

   always_comb begin
      dividend_abs = dividend[WIDTH-1] ? -dividend : dividend;
      divisor_abs  = divisor[WIDTH-1] ? -divisor : divisor;
      r_sh         = {r_q, q_q[WIDTH-1]};
      fits         = r_sh >= {1'b0, d_q};
      r_nx         = fits ? (r_sh[WIDTH-1:0] - d_q) : r_sh[WIDTH-1:0];
      q_nx         = {q_q[WIDTH-2:0], fits};
      quotient     = neg_q_q ? -q_nx : q_nx;
      remainder    = neg_r_q ? -r_nx : r_nx;
      // WIDTH is a power of two, so the final iteration is the all-ones count
      last         = run_q && (&cnt_q);
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         run_q   <= 1'b0;
         cnt_q   <= '0;
         q_q     <= '0;
         r_q     <= '0;
         d_q     <= '0;
         neg_q_q <= 1'b0;
         neg_r_q <= 1'b0;
      end else if (load) begin
         run_q   <= 1'b1;
         cnt_q   <= '0;
         q_q     <= dividend_abs;
         r_q     <= '0;
         d_q     <= divisor_abs;
         neg_q_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
         neg_r_q <= dividend[WIDTH-1];
      end else if (run_q) begin
         q_q   <= q_nx;
         r_q   <= r_nx;
         cnt_q <= cnt_q + CW'(1);
         if (&cnt_q) run_q <= 1'b0;
      end
   end

endmodule

// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle logic/shift ops, iterative Booth multiply and signed divide.
module multicycle_alu
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth,
   parameter int unsigned SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] Ra,
   input  logic [WIDTH-1:0] Rb,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] ZHI,
   output logic [WIDTH-1:0] ZLO
);

   alu_state_e       state_q, state_d;
   logic [3:0]       op_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic [SHW-1:0]   cnt_q;
   logic [WIDTH:0]   acc_q, acc_d, sum;
   logic [WIDTH-1:0] mq_q, mq_d;
   logic             qm1_q;

   logic             accept, div_load, div_last, iter_last;
   logic [WIDTH-1:0] quo, rem, sc_lo;
   logic [SHW-1:0]   amt, neg_amt;
   logic             shift_oob;

   assign accept   = (state_q == StIdle) && start;
   assign div_load = accept && (op == OpDiv);
   assign busy     = (state_q != StIdle);
   assign done     = (state_q == StDone);
   assign iter_last = ((state_q == StMul) && (&cnt_q)) || ((state_q == StDiv) && div_last);

   seq_divider #(
      .WIDTH(WIDTH)
   ) u_div (
      .clk      (clk),
      .clr      (clr),
      .load     (div_load),
      .dividend (Ra),
      .divisor  (Rb),
      .quotient (quo),
      .remainder(rem),
      .last     (div_last)
   );

   // Single-cycle ops are evaluated straight from the inputs on the accepting edge
   always_comb begin
      amt       = Rb[SHW-1:0];
      neg_amt   = -amt;
      shift_oob = |(Rb >> SHW);
      sc_lo     = '0;
      case (op)
         OpAdd: sc_lo = Ra + Rb;
         OpSub: sc_lo = Ra - Rb;
         OpAnd: sc_lo = Ra & Rb;
         OpOr:  sc_lo = Ra | Rb;
         OpShr: sc_lo = shift_oob ? '0 : (Ra >> amt);
         OpShl: sc_lo = shift_oob ? '0 : (Ra << amt);
         OpRor: sc_lo = (Ra >> amt) | (Ra << neg_amt);
         OpRol: sc_lo = (Ra << amt) | (Ra >> neg_amt);
         OpNeg: sc_lo = -Rb;
         OpNot: sc_lo = ~Rb;
         default: sc_lo = '0;
      endcase
   end

   // Radix-2 Booth step; accumulator carries one guard bit for the most-negative multiplicand
   always_comb begin
      case ({mq_q[0], qm1_q})
         2'b01:   sum = acc_q + {b_q[WIDTH-1], b_q};
         2'b10:   sum = acc_q - {b_q[WIDTH-1], b_q};
         default: sum = acc_q;
      endcase
      acc_d = {sum[WIDTH], sum[WIDTH:1]};
      mq_d  = {sum[0], mq_q[WIDTH-1:1]};
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               if (op == OpMul)      state_d = StMul;
               else if (op == OpDiv) state_d = StDiv;
               else                  state_d = StDone;
            end
         end
         StMul, StDiv: if (iter_last) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q  <= StIdle;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         cnt_q    <= '0;
         acc_q    <= '0;
         mq_q     <= '0;
         qm1_q    <= 1'b0;
         div_zero <= 1'b0;
         ZHI      <= '0;
         ZLO      <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q  <= op;
            a_q   <= Ra;
            b_q   <= Rb;
            cnt_q <= '0;
            acc_q <= '0;
            mq_q  <= Ra;
            qm1_q <= 1'b0;
            if (op != OpMul && op != OpDiv) begin
               ZLO      <= sc_lo;
               ZHI      <= '0;
               div_zero <= 1'b0;
            end
         end
         if (state_q == StMul) begin
            acc_q <= acc_d;
            mq_q  <= mq_d;
            qm1_q <= mq_q[0];
            cnt_q <= cnt_q + SHW'(1);
         end
         if (iter_last) begin
            if (op_q == OpDiv) begin
               if (b_q == '0) begin
                  ZLO      <= '1;
                  ZHI      <= a_q;
                  div_zero <= 1'b1;
               end else begin
                  ZLO      <= quo;
                  ZHI      <= rem;
                  div_zero <= 1'b0;
               end
            end else begin
               ZHI      <= acc_d[WIDTH-1:0];
               ZLO      <= mq_d;
               div_zero <= 1'b0;
            end
         end
      end
   end

endmodule
